seg7_disp_arb: RTL and testbench

- Arbitrates ownership of the shared 4-digit seven-segment display between NREQ self-test requesters (IR, RTC, UART, PS/2, USB/SD, ...).
- Decides which requester's mode code and 16-bit value reach the display driver's seg7_type and data inputs.
- Rotates round-robin with a minimum on-screen hold time, supports a manual "next" key and a lock, and falls back to the internal idle pattern when nobody requests.
- Sits between the test modules and the display driver, in the same 100 MHz clock domain.

---
 rtl/seg7_pkg.sv | 44 ++++
 rtl/seg7_ms_prescaler.sv | 37 +++
 rtl/seg7_disp_arb.sv | 147 ++++++++++++++
 tb/tb_seg7_disp_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display arbitration slice.
//   - seg7 mode codes and the mode-code width
//   - FSM state type of the arbiter
//   - rr_search: round-robin search for the next set bit, with wrap-around
package seg7_pkg;

  localparam int unsigned SEG7_TYPE_W = 4;
  localparam int unsigned SEG7_MAX_REQ = 8;

  localparam logic [SEG7_TYPE_W-1:0] SEG7_T_INT  = 4'd0;
  localparam logic [SEG7_TYPE_W-1:0] SEG7_T_IR   = 4'd1;
  localparam logic [SEG7_TYPE_W-1:0] SEG7_T_RTC  = 4'd2;
  localparam logic [SEG7_TYPE_W-1:0] SEG7_T_UART = 4'd3;
  localparam logic [SEG7_TYPE_W-1:0] SEG7_T_PS2  = 4'd6;
  localparam logic [SEG7_TYPE_W-1:0] SEG7_T_USB  = 4'd10;
  localparam logic [SEG7_TYPE_W-1:0] SEG7_T_SD   = 4'd11;
  localparam logic [SEG7_TYPE_W-1:0] SEG7_T_EXT  = 4'd12;

  typedef enum logic {
    StIdle,
    StOwn
  } arb_state_e;

  // Index of the first set bit of vec[n-1:0], scanning from start upwards with wrap-around.
  // Returns 0 when vec is empty; callers qualify the result with their own "any" flag.
  function automatic logic [2:0] rr_search(input logic [SEG7_MAX_REQ-1:0] vec,
                                           input int unsigned start,
                                           input int unsigned n);
    logic [2:0]  win;
    logic        found;
    int unsigned idx;
    win   = 3'd0;
    found = 1'b0;
    for (int unsigned i = 0; i < SEG7_MAX_REQ; i++) begin
      idx = (start + i) % n;
      if (i < n && !found && vec[idx]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/seg7_ms_prescaler.sv
// Millisecond prescaler: free-running counter 0..CLK_PER_MS-1, cleared only by reset.
// Ports:
//   clk     - system clock
//   rstn    - asynchronous active-low reset
//   ms_tick - one-cycle pulse in the cycle following the terminal count
module seg7_ms_prescaler #(
  parameter int unsigned CLK_PER_MS = 100000
) (
  input  logic clk,
  input  logic rstn,
  output logic ms_tick
);

  localparam int unsigned CntW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(CLK_PER_MS - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == TermCnt);
    cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign ms_tick = tick_q;

endmodule

// File: rtl/seg7_disp_arb.sv
// Arbiter for the shared 4-digit seven-segment display.
// Requesters are granted round-robin; a grant is held for at least HOLD_MS ms before a
// hold-expiry rotation, key_next forces a rotation, lock suppresses hold-expiry rotation,
// and the internal idle pattern is shown when nobody requests.
// Ports:
//   clk, rstn  - 100 MHz clock, asynchronous active-low reset
//   req        - per-requester level request
//   req_type   - 4-bit mode code per requester, requester i at [4i+3:4i]
//   req_data   - 16-bit value per requester, requester i at [16i+15:16i]
//   key_next   - debounced one-cycle pulse forcing a rotation
//   lock       - suppresses hold-expiry rotation while high
//   gnt        - one-hot grant or all zeros
//   seg7_type  - mode code to the display driver
//   seg7_data  - value to the display driver
//   ms_tick    - 1 ms pulse, exported for the display scan logic
module seg7_disp_arb
  import seg7_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned CLK_PER_MS = 100000,
  parameter int unsigned HOLD_MS    = 2000,
  parameter logic [3:0]  IDLE_TYPE  = 4'd0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req,
  input  logic [4*NREQ-1:0]  req_type,
  input  logic [16*NREQ-1:0] req_data,
  input  logic               key_next,
  input  logic               lock,
  output logic [NREQ-1:0]    gnt,
  output logic [3:0]         seg7_type,
  output logic [15:0]        seg7_data,
  output logic               ms_tick
);

  localparam int unsigned IdxW  = $clog2(NREQ);
  localparam int unsigned HoldW = $clog2(HOLD_MS + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_MS);

  arb_state_e       state_q, state_d;
  logic [IdxW-1:0]  cur_q, cur_d;
  logic [HoldW-1:0] hold_q, hold_d;

  logic [NREQ-1:0]         cur_oh;
  logic [NREQ-1:0]         others;
  logic                    others_any;
  logic [SEG7_MAX_REQ-1:0] req_ext;
  logic [SEG7_MAX_REQ-1:0] others_ext;
  logic [IdxW-1:0]         win_all;
  logic [IdxW-1:0]         win_other;
  logic [NREQ-1:0]         gnt_d;
  logic [3:0]              type_d;
  logic [15:0]             data_d;

  seg7_ms_prescaler #(
    .CLK_PER_MS(CLK_PER_MS)
  ) u_prescaler (
    .clk    (clk),
    .rstn   (rstn),
    .ms_tick(ms_tick)
  );

  // Round-robin candidates: win_all may return cur itself (searched last), win_other never does.
  always_comb begin
    cur_oh     = {{(NREQ-1){1'b0}}, 1'b1} << cur_q;
    others     = req & ~cur_oh;
    others_any = |others;
    req_ext    = '0;
    others_ext = '0;
    req_ext[NREQ-1:0]    = req;
    others_ext[NREQ-1:0] = others;
    win_all   = IdxW'(rr_search(req_ext, int'(cur_q) + 1, NREQ));
    win_other = IdxW'(rr_search(others_ext, int'(cur_q) + 1, NREQ));
  end

  // Next-state decision; triggers in OWN are prioritised drop > key_next > hold expiry.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    hold_d  = hold_q;
    case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StOwn;
          cur_d   = win_all;
          hold_d  = '0;
        end
      end
      StOwn: begin
        if (!req[cur_q]) begin
          // A simultaneous key_next is absorbed by the drop rotation.
          if (others_any) begin
            cur_d  = win_other;
            hold_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else if (key_next) begin
          // With no other requester the owner is kept but its hold time restarts.
          if (others_any) begin
            cur_d = win_other;
          end
          hold_d = '0;
        end else if (hold_q == HoldMax && !lock && others_any) begin
          cur_d  = win_other;
          hold_d = '0;
        end else if (ms_tick && hold_q != HoldMax) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs follow the next owner so a grant change is visible one cycle after its trigger.
  always_comb begin
    if (state_d == StOwn) begin
      gnt_d  = {{(NREQ-1){1'b0}}, 1'b1} << cur_d;
      type_d = req_type[4*cur_d +: 4];
      data_d = req_data[16*cur_d +: 16];
    end else begin
      gnt_d  = '0;
      type_d = IDLE_TYPE;
      data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      cur_q     <= '0;
      hold_q    <= '0;
      gnt       <= '0;
      seg7_type <= IDLE_TYPE;
      seg7_data <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      hold_q    <= hold_d;
      gnt       <= gnt_d;
      seg7_type <= type_d;
      seg7_data <= data_d;
    end
  end

endmodule

// File: tb/tb_seg7_disp_arb.sv
module tb_seg7_disp_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned CPMS = 10;
  localparam int unsigned HOLD = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req;
  logic [15:0] req_type;
  logic [63:0] req_data;
  logic        key_next;
  logic        lock;
  logic [3:0]  gnt;
  logic [3:0]  seg7_type;
  logic [15:0] seg7_data;
  logic        ms_tick;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner index (-1 = nobody), last granted index, ms held, edges since reset.
  int          m_own;
  int          m_last;
  int          m_hold;
  int          m_edges;
  logic        m_tick;
  logic [3:0]  e_gnt;
  logic [3:0]  e_type;
  logic [15:0] e_data;

  seg7_disp_arb #(
    .NREQ      (NREQ),
    .CLK_PER_MS(CPMS),
    .HOLD_MS   (HOLD),
    .IDLE_TYPE (4'd0)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .req_type (req_type),
    .req_data (req_data),
    .key_next (key_next),
    .lock     (lock),
    .gnt      (gnt),
    .seg7_type(seg7_type),
    .seg7_data(seg7_data),
    .ms_tick  (ms_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // First requester set in r scanning upward from 'from' with wrap, skipping excl.
  function automatic int pick(input logic [3:0] r, input int from, input int excl);
    int idx;
    for (int i = 0; i < 4; i++) begin
      idx = (from + i) % 4;
      if (r[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_own   = -1;
    m_last  = 0;
    m_hold  = 0;
    m_edges = 0;
    m_tick  = 1'b0;
    e_gnt   = '0;
    e_type  = '0;
    e_data  = '0;
  endtask

  task automatic model_step();
    int   w;
    logic tick_in;
    tick_in = m_tick;
    m_edges++;
    m_tick = (m_edges % CPMS == 0);
    if (m_own < 0) begin
      if (req != 0) begin
        m_own  = pick(req, m_last + 1, -1);
        m_last = m_own;
        m_hold = 0;
      end
    end else begin
      w = pick(req, m_own + 1, m_own);
      if (!req[m_own]) begin
        if (w >= 0) begin
          m_own  = w;
          m_last = w;
          m_hold = 0;
        end else begin
          m_own = -1;
        end
      end else if (key_next) begin
        if (w >= 0) begin
          m_own  = w;
          m_last = w;
        end
        m_hold = 0;
      end else if (m_hold >= HOLD && !lock && w >= 0) begin
        m_own  = w;
        m_last = w;
        m_hold = 0;
      end else if (tick_in && m_hold < HOLD) begin
        m_hold++;
      end
    end
    if (m_own < 0) begin
      e_gnt  = '0;
      e_type = '0;
      e_data = '0;
    end else begin
      e_gnt  = 4'(1 << m_own);
      e_type = req_type[4*m_own +: 4];
      e_data = req_data[16*m_own +: 16];
    end
  endtask

  task automatic check_outputs();
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("seg7_type", 32'(seg7_type), 32'(e_type));
    check("seg7_data", 32'(seg7_data), 32'(e_data));
    check("ms_tick", 32'(ms_tick), 32'(m_tick));
  endtask

  // Inputs are changed at the negedge; the model steps on the posedge and results are
  // compared at the following negedge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rstn) model_step();
      @(negedge clk);
      check_outputs();
    end
  endtask

  task automatic pulse_next();
    key_next = 1'b1;
    step(1);
    key_next = 1'b0;
  endtask

  // Asynchronous reset between clock edges, held across one posedge.
  task automatic mid_reset();
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_type", 32'(seg7_type), 32'd0);
    check("rst_data", 32'(seg7_data), 32'd0);
    check("rst_tick", 32'(ms_tick), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rstn = 1'b1;
  endtask

  initial begin
    rstn     = 1'b0;
    req      = '0;
    req_type = {4'd12, 4'd2, 4'd10, 4'd1};
    req_data = {16'hd003, 16'h1230, 16'hb001, 16'ha000};
    key_next = 1'b0;
    lock     = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rstn = 1'b1;

    // Idle: nothing granted, ms_tick every CPMS cycles.
    step(25);

    // Single requester r2, data refreshed live.
    req = 4'b0100;
    step(3);
    req_data[47:32] = 16'h1231;
    step(2);

    // r0 joins: r2 rotates out on hold expiry, wrapping to r0.
    req = 4'b0101;
    step(45);

    // Lock keeps the current owner despite a pending requester.
    lock = 1'b1;
    step(50);
    lock = 1'b0;
    step(40);

    // key_next rotates; with a lone requester it only clears the hold time.
    req = 4'b0011;
    step(12);
    pulse_next();
    step(4);
    req = 4'b0010;
    step(2);
    pulse_next();
    step(5);

    // Drop to idle, then drop and key_next together.
    req = 4'b0000;
    step(3);
    req = 4'b0010;
    step(3);
    req = 4'b1010;
    step(2);
    req      = 4'b1000;
    key_next = 1'b1;
    step(1);
    key_next = 1'b0;
    step(5);

    // key_next while idle is ignored.
    req = 4'b0000;
    step(2);
    pulse_next();
    step(2);

    // Reset mid-grant, then re-grant.
    req = 4'b0100;
    step(4);
    mid_reset();
    step(4);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) lock = ~lock;
      if ($urandom_range(0, 9) == 0) req_data[16*$urandom_range(0, 3) +: 16] = 16'($urandom);
      if ($urandom_range(0, 29) == 0) req_type[4*$urandom_range(0, 3) +: 4] = 4'($urandom);
      key_next = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 999) == 0) begin
        key_next = 1'b0;
        mid_reset();
      end else begin
        step(1);
      end
    end
    key_next = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
